// File: rtl/oh_pkg.sv
// Shared definitions for the two-requester operand arbiter: select codes,
// FSM state encoding and the shift-op classifier.
package oh_pkg;

    localparam logic [2:0] SEL_RB    = 3'b000;
    localparam logic [2:0] SEL_IMM11 = 3'b001;
    localparam logic [2:0] SEL_IMM14 = 3'b010;
    localparam logic [2:0] SEL_IMM21 = 3'b011;
    localparam logic [2:0] SEL_SHR   = 3'b100;
    localparam logic [2:0] SEL_SRA   = 3'b101;
    localparam logic [2:0] SEL_SHL   = 3'b110;
    localparam logic [2:0] SEL_ZERO  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC2 = 2'd1,
        ST_FULL  = 2'd2
    } oh_state_e;

    // Shift ops take a second cycle through the datapath.
    function automatic logic is_shift(input logic [2:0] sel);
        return (sel == SEL_SHR) || (sel == SEL_SRA) || (sel == SEL_SHL);
    endfunction

endpackage

// File: rtl/oh_datapath.sv
// Combinational operand generator: produces N from RB, the immediate field
// and the operand-select code.
module oh_datapath
    import oh_pkg::*;
(
    input  logic [31:0] rb,
    input  logic [20:0] imm,
    input  logic [2:0]  sel,
    output logic [31:0] n
);

    logic [4:0] shamt;

    assign shamt = 5'(5'd31 - imm[9:5]);

    always_comb begin
        n = 32'd0;
        case (sel)
            SEL_RB:    n = rb;
            SEL_IMM11: n = {{22{imm[0]}}, imm[10:1]};
            SEL_IMM14: n = {{19{imm[0]}}, imm[13:1]};
            SEL_IMM21: n = {imm, 11'b0};
            SEL_SHR:   n = rb >> shamt;
            SEL_SRA:   n = $unsigned($signed(rb) >>> shamt);
            SEL_SHL:   n = rb << shamt;
            SEL_ZERO:  n = 32'd0;
            default:   n = 32'd0;
        endcase
    end

endmodule

// File: rtl/oh_arbiter.sv
// Two-requester arbiter feeding a one-entry output register through a shared
// operand datapath. Define OH_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise req0 has fixed priority.
module oh_arbiter
    import oh_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rb,
    input  logic [20:0] req0_i,
    input  logic [2:0]  req0_s,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rb,
    input  logic [20:0] req1_i,
    input  logic [2:0]  req1_s,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_n,
    output logic        out_id,

    output logic [1:0]  dbg_state,
    output logic        dbg_last_grant
);

    // Handshake: a request transfers on a rising edge where its valid and
    // ready are both 1; the result transfers where out_valid and out_ready
    // are both 1. Valid must not depend on ready.

    oh_state_e   state;
    logic        last_grant;

    logic [31:0] op_rb;
    logic [20:0] op_i;
    logic [2:0]  op_s;
    logic        op_id;

    logic        can_accept;
    logic        sel1;
    logic        accept;

    logic [31:0] dp_rb;
    logic [20:0] dp_i;
    logic [2:0]  dp_s;
    logic [31:0] dp_n;

    assign can_accept = rst_n && ((state == ST_IDLE) || ((state == ST_FULL) && out_ready));

`ifdef OH_ARB_ROUND_ROBIN_EN
    // On contention the requester that was not granted last wins.
    assign sel1 = req1_valid && (!req0_valid || !last_grant);
`else
    assign sel1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = can_accept && req0_valid && !sel1;
    assign req1_ready = can_accept && sel1;
    assign accept     = req0_ready || req1_ready;

    // EXEC2 replays the latched operands; otherwise the winner feeds the datapath.
    always_comb begin
        dp_rb = sel1 ? req1_rb : req0_rb;
        dp_i  = sel1 ? req1_i  : req0_i;
        dp_s  = sel1 ? req1_s  : req0_s;
        if (state == ST_EXEC2) begin
            dp_rb = op_rb;
            dp_i  = op_i;
            dp_s  = op_s;
        end
    end

    oh_datapath u_datapath (
        .rb  (dp_rb),
        .imm (dp_i),
        .sel (dp_s),
        .n   (dp_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_n      <= 32'd0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
            op_rb      <= 32'd0;
            op_i       <= 21'd0;
            op_s       <= 3'd0;
            op_id      <= 1'b0;
        end else if (state == ST_EXEC2) begin
            out_n     <= dp_n;
            out_id    <= op_id;
            out_valid <= 1'b1;
            state     <= ST_FULL;
        end else if (accept) begin
            last_grant <= sel1;
            if (is_shift(dp_s)) begin
                op_rb     <= dp_rb;
                op_i      <= dp_i;
                op_s      <= dp_s;
                op_id     <= sel1;
                out_valid <= 1'b0;
                state     <= ST_EXEC2;
            end else begin
                out_n     <= dp_n;
                out_id    <= sel1;
                out_valid <= 1'b1;
                state     <= ST_FULL;
            end
        end else if ((state == ST_FULL) && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
        end
    end

    assign dbg_state      = state;
    assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_oh_arbiter.sv
// Randomized bench for oh_arbiter against a transaction-level reference model.
module tb_oh_arbiter;
    import oh_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rb, req1_rb;
    logic [20:0] req0_i, req1_i;
    logic [2:0]  req0_s, req1_s;
    logic        out_valid, out_ready;
    logic [31:0] out_n;
    logic        out_id;
    logic [1:0]  dbg_state;
    logic        dbg_last_grant;

    int n_vec = 0;
    int n_err = 0;

    // reference model: output slot, pending two-cycle op, arbitration history
    logic        m_valid   = 1'b0;
    logic [31:0] m_n       = 32'd0;
    logic        m_id      = 1'b0;
    logic        m_pending = 1'b0;
    logic [31:0] m_pend_n  = 32'd0;
    logic        m_pend_id = 1'b0;
    logic        m_last    = 1'b1;

    always #5 clk = ~clk;

    oh_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_rb        (req0_rb),
        .req0_i         (req0_i),
        .req0_s         (req0_s),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_rb        (req1_rb),
        .req1_i         (req1_i),
        .req1_s         (req1_s),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_n          (out_n),
        .out_id         (out_id),
        .dbg_state      (dbg_state),
        .dbg_last_grant (dbg_last_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_n(input logic [31:0] rb, input logic [20:0] i,
                                          input logic [2:0] s);
        int amt;
        int signed v;
        amt = 31 - int'(i[9:5]);
        case (s)
            3'd0: return rb;
            3'd1: begin v = int'(i[10:1]) - (i[0] ? 1024 : 0); return 32'(v); end
            3'd2: begin v = int'(i[13:1]) - (i[0] ? 8192 : 0); return 32'(v); end
            3'd3: return 32'(i) * 32'd2048;
            3'd4: return rb >> amt;
            3'd5: return $unsigned($signed(rb) >>> amt);
            3'd6: return rb << amt;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive at negedge, compare at negedge+1, advance model at posedge.
    task automatic step(input logic rst, input logic v0, input logic v1,
                        input logic [31:0] rb0, input logic [20:0] i0, input logic [2:0] s0,
                        input logic [31:0] rb1, input logic [20:0] i1, input logic [2:0] s1,
                        input logic ordy);
        logic can, w, exp_r0, exp_r1;
        logic [1:0] exp_st;
        logic [31:0] res;
        @(negedge clk);
        rst_n = rst; req0_valid = v0; req1_valid = v1;
        req0_rb = rb0; req0_i = i0; req0_s = s0;
        req1_rb = rb1; req1_i = i1; req1_s = s1;
        out_ready = ordy;
        #1;
        can = rst && !m_pending && (!m_valid || ordy) && (v0 || v1);
`ifdef OH_ARB_ROUND_ROBIN_EN
        w = (v0 && v1) ? !m_last : v1;
`else
        w = !v0;
`endif
        exp_r0 = can && !w;
        exp_r1 = can && w;
        exp_st = m_pending ? ST_EXEC2 : (m_valid ? ST_FULL : ST_IDLE);
        check("req0_ready", 32'(req0_ready), 32'(exp_r0));
        check("req1_ready", 32'(req1_ready), 32'(exp_r1));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("state", 32'(dbg_state), 32'(exp_st));
        if (m_valid) begin
            check("out_n", out_n, m_n);
            check("out_id", 32'(out_id), 32'(m_id));
        end
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_pending = 0; m_n = 0; m_id = 0; m_last = 1;
        end else if (m_pending) begin
            m_pending = 0; m_valid = 1; m_n = m_pend_n; m_id = m_pend_id;
        end else if (can) begin
            res = w ? ref_n(rb1, i1, w ? s1 : s0) : ref_n(rb0, i0, s0);
            m_last = w;
            if ((w ? s1 : s0) inside {3'd4, 3'd5, 3'd6}) begin
                m_pending = 1; m_valid = 0; m_pend_n = res; m_pend_id = w;
            end else begin
                m_valid = 1; m_n = res; m_id = w;
            end
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
    endtask

    task automatic idle_cycle(input logic ordy);
        step(1'b1, 1'b0, 1'b0, 32'd0, 21'd0, 3'd0, 32'd0, 21'd0, 3'd0, ordy);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0, 21'd0, 3'd0, 32'd0, 21'd0, 3'd0, 1'b1);
    endtask

    initial begin
        logic [1:0] exp_ids [4];
        rst_n = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
        req0_rb = 0; req0_i = 0; req0_s = 0; req1_rb = 0; req1_i = 0; req1_s = 0;
        repeat (2) @(posedge clk);

        // reset state
        do_reset();
        #1;
        check("rst_out_n", out_n, 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_last", 32'(dbg_last_grant), 32'd1);

        // req0 pass-through of RB
        step(1'b1, 1'b1, 1'b0, 32'h12345678, 21'd0, SEL_RB, 32'd0, 21'd0, 3'd0, 1'b1);
        #1;
        check("rb_n", out_n, 32'h12345678);
        check("rb_id", 32'(out_id), 32'd0);
        check("rb_valid", 32'(out_valid), 32'd1);
        idle_cycle(1'b1);

        // req1 21-bit immediate
        step(1'b1, 1'b0, 1'b1, 32'd0, 21'd0, 3'd0, 32'd0, 21'h000001, SEL_IMM21, 1'b1);
        #1;
        check("imm21_n", out_n, 32'h00000800);
        check("imm21_id", 32'(out_id), 32'd1);
        idle_cycle(1'b1);

        // two-cycle arithmetic and logical right shifts
        step(1'b1, 1'b1, 1'b0, 32'h80000000, 21'(27 << 5), SEL_SRA, 32'd0, 21'd0, 3'd0, 1'b1);
        #1;
        check("sra_state", 32'(dbg_state), 32'(ST_EXEC2));
        step(1'b1, 1'b1, 1'b1, 32'h1, 21'd0, SEL_RB, 32'h2, 21'd0, SEL_RB, 1'b1);
        #1;
        check("sra_n", out_n, 32'hF8000000);
        idle_cycle(1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h80000000, 21'(27 << 5), SEL_SHR, 32'd0, 21'd0, 3'd0, 1'b1);
        idle_cycle(1'b1);
        #1;
        check("shr_n", out_n, 32'h08000000);
        idle_cycle(1'b1);

        // contention for four cycles
        do_reset();
`ifdef OH_ARB_ROUND_ROBIN_EN
        exp_ids = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b1, 32'(k), 21'd0, SEL_RB, 32'(k + 100), 21'd0, SEL_RB, 1'b1);
            #1;
            check("contend_id", 32'(out_id), 32'(exp_ids[k]));
        end
        idle_cycle(1'b1);

        // backpressure: hold for three cycles, then drain and accept together
        step(1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 21'd0, SEL_RB, 32'd0, 21'd0, 3'd0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b1, 32'h1111, 21'd0, SEL_RB, 32'h2222, 21'd0, SEL_RB, 1'b0);
        #1;
        check("bp_hold_n", out_n, 32'hCAFEF00D);
        step(1'b1, 1'b0, 1'b1, 32'd0, 21'd0, 3'd0, 32'h5A5A5A5A, 21'd0, SEL_RB, 1'b1);
        #1;
        check("bp_next_n", out_n, 32'h5A5A5A5A);
        idle_cycle(1'b1);

        // reset during EXEC2 discards the pending shift
        step(1'b1, 1'b1, 1'b0, 32'hFFFF0000, 21'(3 << 5), SEL_SHL, 32'd0, 21'd0, 3'd0, 1'b1);
        do_reset();
        #1;
        check("rst_exec2_valid", 32'(out_valid), 32'd0);
        check("rst_exec2_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) idle_cycle(1'b1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                 $urandom, 21'($urandom), 3'($urandom_range(0, 7)),
                 $urandom, 21'($urandom), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
